// File: rtl/dna_ascii_encoder.sv
// dna_ascii_encoder: FASTA ASCII stream to 2-bit nucleotide codes, buffered in a show-ahead FIFO.
module dna_ascii_encoder #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             m_ready,
   output logic [1:0]       dna_out,
   output logic             dna_valid,
   output logic             dna_first,
   output logic             err_pulse,
   output logic [CNT_W-1:0] base_count,
   output logic [CNT_W-1:0] err_count
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {ST_SEQ, ST_HDR} state_t;
   state_t state, state_nx;
   logic [2:0] mem [DEPTH];
   logic [2:0] last, head;
   logic [AW:0] wp, rp, wp_nx, rp_nx;
   logic [7:0] lc;
   logic [1:0] code;
   logic acc, is_base, is_ws, is_gt, is_lf, push, pop, hdr_start, bad, empty, full_nx, first_pend;
   assign acc = s_valid && s_ready;
   // setting bit 5 folds upper-case letters onto lower-case and no other byte lands on a/c/g/t
   assign lc = s_data | 8'h20;
   assign is_base = lc == 8'h61 || lc == 8'h63 || lc == 8'h67 || lc == 8'h74;
   assign code = lc == 8'h61 ? 2'd0 : lc == 8'h63 ? 2'd1 : lc == 8'h67 ? 2'd2 : 2'd3;
   assign is_ws = s_data == 8'h20 || s_data == 8'h09 || s_data == 8'h0D || s_data == 8'h0A;
   assign is_gt = s_data == 8'h3E;
   assign is_lf = s_data == 8'h0A;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_SEQ;
      else state <= state_nx;
   always_comb
      state_nx = state == ST_SEQ ? (acc && is_gt ? ST_HDR : ST_SEQ) : (acc && is_lf ? ST_SEQ : ST_HDR);
   always_comb begin
      push = acc && state == ST_SEQ && is_base;
      hdr_start = acc && state == ST_SEQ && is_gt;
      bad = acc && state == ST_SEQ && !is_base && !is_ws && !is_gt;
   end
   assign empty = wp == rp;
   assign pop = !empty && m_ready;
   assign wp_nx = wp + {{AW{1'b0}}, push};
   assign rp_nx = rp + {{AW{1'b0}}, pop};
   assign full_nx = wp_nx[AW] != rp_nx[AW] && wp_nx[AW-1:0] == rp_nx[AW-1:0];
   assign head = mem[rp[AW-1:0]];
   assign dna_valid = !empty;
   // outputs hold the last popped entry while the FIFO is empty
   assign {dna_first, dna_out} = empty ? last : head;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         s_ready <= 1'b0;
         first_pend <= 1'b0;
         err_pulse <= 1'b0;
         base_count <= '0;
         err_count <= '0;
         last <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         wp <= wp_nx;
         rp <= rp_nx;
         s_ready <= !full_nx;
         if (push) mem[wp[AW-1:0]] <= {first_pend, code};
         if (pop) last <= head;
         first_pend <= hdr_start || (first_pend && !push);
         err_pulse <= bad;
         base_count <= hdr_start ? '0 : (push && !(&base_count)) ? base_count + 1'b1 : base_count;
         err_count <= (bad && !(&err_count)) ? err_count + 1'b1 : err_count;
      end
endmodule
